sram_arbiter: RTL and testbench

Two-requester arbiter for the single-port data SRAM, between the RV32E core's memory port and a DMA/pixel-loader port. The core has fixed priority. The DMA is served in idle core cycles. An anti-starvation counter forces a one-cycle core stall after a bounded wait. The block sits between the core's `sram_*` outputs and the SRAM macro; all SRAM strobes are active-low.

---
 rtl/sram_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single-port data SRAM: the core has fixed priority,
// the DMA port is served in idle core cycles, and a bounded wait forces a one-cycle core stall.
module sram_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        core_cen,
  input  logic        core_wen,
  input  logic [3:0]  core_ben,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_din,
  output logic [31:0] core_dout,
  output logic        core_stall,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_ben,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,

  output logic        sram_cen,
  output logic        sram_wen,
  output logic [3:0]  sram_ben,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);

  typedef enum logic {
    SHARE,
    STALL
  } state_t;

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic [7:0] wait_inc;
  logic       conflict;
  logic       dma_rd_pend;

  assign conflict = (state == SHARE) && dma_req && !core_cen;
  assign wait_inc = wait_cnt + 8'd1;

  // Arbitration FSM: every path that is not a conflict cycle clears the wait count.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    wait_cnt_nxt = 8'd0;
    dma_gnt      = 1'b0;
    core_stall   = 1'b0;

    case (state)
      SHARE: begin
        if (conflict) begin
          wait_cnt_nxt = wait_inc;
          if (wait_inc == MAX_WAIT_CNT) begin
            state_nxt = STALL;
          end
        end else if (dma_req) begin
          dma_gnt = 1'b1;
        end
      end
      STALL: begin
        core_stall = 1'b1;
        dma_gnt    = dma_req;
        state_nxt  = SHARE;
      end
      default: begin
        state_nxt = SHARE;
      end
    endcase

    // Reset is synchronous, but the strobes must already be quiet during the reset cycle.
    if (!rst_n) begin
      dma_gnt    = 1'b0;
      core_stall = 1'b0;
    end
  end

  // SRAM port mux; a stall cycle without a DMA request leaves the macro deselected.
  always_comb begin
    sram_cen  = core_cen;
    sram_wen  = core_wen;
    sram_ben  = core_ben;
    sram_addr = core_addr;
    sram_din  = core_din;

    if (dma_gnt) begin
      sram_cen  = 1'b0;
      sram_wen  = !dma_we;
      sram_ben  = dma_ben;
      sram_addr = dma_addr;
      sram_din  = dma_wdata;
    end else if (core_stall) begin
      sram_cen  = 1'b1;
      sram_wen  = 1'b1;
    end

    if (!rst_n) begin
      sram_cen = 1'b1;
      sram_wen = 1'b1;
      sram_ben = 4'hF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SHARE;
      wait_cnt    <= 8'd0;
      dma_rd_pend <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      dma_rd_pend <= dma_gnt & !dma_we;
    end
  end

  // Read data is shared; the pending flag tells the DMA side when it is meant for it.
  assign core_dout  = sram_dout;
  assign dma_rdata  = sram_dout;
  assign dma_rvalid = dma_rd_pend & rst_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized run
// scored against a conflict-run-length reference model and a reference memory.
module tb_sram_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_cen, core_wen;
  logic [3:0]  core_ben;
  logic [31:0] core_addr, core_din, core_dout;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [3:0]  dma_ben;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_addr, sram_din;
  logic [31:0] sram_dout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always #5 clk = ~clk;

  sram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_cen  (core_cen),
    .core_wen  (core_wen),
    .core_ben  (core_ben),
    .core_addr (core_addr),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_stall(core_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_ben   (dma_ben),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_ben  (sram_ben),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Behavioural single-port SRAM macro: one-cycle read latency, active-low strobes.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr[9:2]];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] ben);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (!ben[b]) merge[8*b +: 8] = data[8*b +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_cen  = 1'b1;  core_wen  = 1'b1;  core_ben = 4'hF;
    core_addr = '0;    core_din  = '0;
    dma_req   = 1'b0;  dma_we    = 1'b0;  dma_ben  = 4'hF;
    dma_addr  = '0;    dma_wdata = '0;
  endtask

  // Core reads 0x40 every cycle while the DMA holds a write to 0x200.
  task automatic setup_conflict();
    idle_inputs();
    core_cen  = 1'b0;  core_addr = 32'h40;
    dma_req   = 1'b1;  dma_we    = 1'b1;  dma_ben = 4'h0;
    dma_addr  = 32'h200;  dma_wdata = 32'hA5A5_0001;
  endtask

  task automatic run_conflict(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++; if (dma_gnt !== 1'b0) $display("FAIL %s_gnt[%0d]: got %b want 0", tag, i, dma_gnt); else n_pass++;
      n_checks++; if (core_stall !== 1'b0) $display("FAIL %s_stall[%0d]: got %b want 0", tag, i, core_stall); else n_pass++;
      n_checks++; if (sram_addr !== core_addr) $display("FAIL %s_addr[%0d]: got %h want %h", tag, i, sram_addr, core_addr); else n_pass++;
      tick();
    end
  endtask

  task automatic expect_stall(input string tag);
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b1) $display("FAIL %s_stall: got %b want 1", tag, core_stall); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL %s_gnt: got %b want 1", tag, dma_gnt); else n_pass++;
    n_checks++; if (sram_addr !== dma_addr) $display("FAIL %s_addr: got %h want %h", tag, sram_addr, dma_addr); else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    dma_req  = 1'b1;
    core_cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (sram_cen !== 1'b1) $display("FAIL reset_cen[%0d]: got %b want 1", i, sram_cen); else n_pass++;
      n_checks++; if (dma_gnt !== 1'b0) $display("FAIL reset_gnt[%0d]: got %b want 0", i, dma_gnt); else n_pass++;
      n_checks++; if (core_stall !== 1'b0) $display("FAIL reset_stall[%0d]: got %b want 0", i, core_stall); else n_pass++;
      n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL reset_rvalid[%0d]: got %b want 0", i, dma_rvalid); else n_pass++;
      tick();
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_write_read();
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b1; dma_ben = 4'h0;
    dma_addr = 32'h100; dma_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL wr_gnt: got %b want 1", dma_gnt); else n_pass++;
    n_checks++; if (sram_cen !== 1'b0) $display("FAIL wr_cen: got %b want 0", sram_cen); else n_pass++;
    n_checks++; if (sram_wen !== 1'b0) $display("FAIL wr_wen: got %b want 0", sram_wen); else n_pass++;
    n_checks++; if (sram_addr !== 32'h100) $display("FAIL wr_addr: got %h want 00000100", sram_addr); else n_pass++;
    n_checks++; if (sram_din !== 32'hDEAD_BEEF) $display("FAIL wr_din: got %h want deadbeef", sram_din); else n_pass++;
    n_checks++; if (core_stall !== 1'b0) $display("FAIL wr_stall: got %b want 0", core_stall); else n_pass++;
    tick();
    dma_addr = 32'h104; dma_wdata = 32'h1234_5678;
    tick();
    dma_we = 1'b0; dma_addr = 32'h100;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL rd_gnt: got %b want 1", dma_gnt); else n_pass++;
    n_checks++; if (sram_wen !== 1'b1) $display("FAIL rd_wen: got %b want 1", sram_wen); else n_pass++;
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rd_rvalid_early: got %b want 0", dma_rvalid); else n_pass++;
    tick();
    dma_addr = 32'h104;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b1) $display("FAIL b2b_rvalid0: got %b want 1", dma_rvalid); else n_pass++;
    n_checks++; if (dma_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b_rdata0: got %h want deadbeef", dma_rdata); else n_pass++;
    tick();
    dma_req = 1'b0;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b1) $display("FAIL b2b_rvalid1: got %b want 1", dma_rvalid); else n_pass++;
    n_checks++; if (dma_rdata !== 32'h1234_5678) $display("FAIL b2b_rdata1: got %h want 12345678", dma_rdata); else n_pass++;
    n_checks++; if (sram_cen !== 1'b1) $display("FAIL idle_cen: got %b want 1", sram_cen); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rvalid_drop: got %b want 0", dma_rvalid); else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    setup_conflict();
    run_conflict(MAX_WAIT, "starve");
    expect_stall("starve_grant");
    dma_req = 1'b0;
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b0) $display("FAIL starve_after_stall: got %b want 0", core_stall); else n_pass++;
    n_checks++; if (sram_cen !== 1'b0) $display("FAIL starve_after_cen: got %b want 0", sram_cen); else n_pass++;
    n_checks++; if (sram_addr !== 32'h40) $display("FAIL starve_after_addr: got %h want 00000040", sram_addr); else n_pass++;
    tick();
  endtask

  task automatic test_count_clear();
    setup_conflict();
    run_conflict(5, "clear_pre");
    core_cen = 1'b1;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL clear_idle_gnt: got %b want 1", dma_gnt); else n_pass++;
    n_checks++; if (core_stall !== 1'b0) $display("FAIL clear_idle_stall: got %b want 0", core_stall); else n_pass++;
    tick();
    core_cen = 1'b0;
    dma_addr = 32'h204;
    run_conflict(MAX_WAIT, "clear_post");
    expect_stall("clear_grant");
    idle_inputs();
    tick();
  endtask

  task automatic test_withdrawal();
    setup_conflict();
    run_conflict(MAX_WAIT - 1, "wd_pre");
    dma_req = 1'b0;
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b0) $display("FAIL wd_drop_stall: got %b want 0", core_stall); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b0) $display("FAIL wd_drop_gnt: got %b want 0", dma_gnt); else n_pass++;
    tick();
    dma_req = 1'b1;
    run_conflict(MAX_WAIT, "wd_post");
    expect_stall("wd_grant");
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_no_req();
    setup_conflict();
    run_conflict(MAX_WAIT, "noreq_pre");
    dma_req = 1'b0;
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b1) $display("FAIL noreq_stall: got %b want 1", core_stall); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b0) $display("FAIL noreq_gnt: got %b want 0", dma_gnt); else n_pass++;
    n_checks++; if (sram_cen !== 1'b1) $display("FAIL noreq_cen: got %b want 1", sram_cen); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b0) $display("FAIL noreq_return: got %b want 0", core_stall); else n_pass++;
    n_checks++; if (sram_cen !== 1'b0) $display("FAIL noreq_core_cen: got %b want 0", sram_cen); else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    setup_conflict();
    run_conflict(MAX_WAIT, "rstmid_pre");
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (core_stall !== 1'b0) $display("FAIL rstmid_stall: got %b want 0", core_stall); else n_pass++;
    n_checks++; if (dma_gnt !== 1'b0) $display("FAIL rstmid_gnt: got %b want 0", dma_gnt); else n_pass++;
    n_checks++; if (sram_cen !== 1'b1) $display("FAIL rstmid_cen: got %b want 1", sram_cen); else n_pass++;
    tick();
    rst_n = 1'b1;
    run_conflict(MAX_WAIT, "rstmid_post");
    expect_stall("rstmid_grant");
    idle_inputs();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100;
    @(negedge clk);
    n_checks++; if (dma_gnt !== 1'b1) $display("FAIL rstrd_gnt: got %b want 1", dma_gnt); else n_pass++;
    tick();
    dma_req = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rstrd_rvalid_in_rst: got %b want 0", dma_rvalid); else n_pass++;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (dma_rvalid !== 1'b0) $display("FAIL rstrd_rvalid_after: got %b want 0", dma_rvalid); else n_pass++;
    n_checks++; if (core_stall !== 1'b0) $display("FAIL rstrd_stall_after: got %b want 0", core_stall); else n_pass++;
    tick();
  endtask

  // Reference model: the DMA is owed a forced slot once its run of consecutive
  // conflict cycles reaches MAX_WAIT; any other cycle resets the run.
  task automatic test_random(input int cycles);
    int          run;
    bit          owed;
    bit          core_hold;
    bit          txn_active;
    bit          exp_stall, exp_gnt, exp_cen, exp_wen;
    logic [3:0]  exp_ben;
    logic [31:0] exp_addr, exp_din;
    bit          dma_pend, core_pend;
    logic [31:0] dma_exp, core_exp;
    int          idx;

    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    run = 0; owed = 0; core_hold = 0; txn_active = 0;
    dma_pend = 0; core_pend = 0; dma_exp = '0; core_exp = '0;

    for (int c = 0; c < cycles; c++) begin
      if (!core_hold) begin
        core_cen  = ($urandom_range(0, 9) < 3);
        core_wen  = 1'($urandom_range(0, 1));
        core_ben  = 4'($urandom_range(0, 15));
        core_addr = 32'($urandom_range(0, 255)) << 2;
        core_din  = $urandom;
      end
      if (!txn_active && $urandom_range(0, 2) == 0) begin
        txn_active = 1;
        dma_we     = 1'($urandom_range(0, 1));
        dma_ben    = 4'($urandom_range(0, 15));
        dma_addr   = 32'($urandom_range(0, 255)) << 2;
        dma_wdata  = $urandom;
      end
      dma_req = txn_active && !(!owed && $urandom_range(0, 9) == 0);

      exp_stall = owed;
      exp_gnt   = owed ? dma_req : (dma_req && core_cen);
      if (exp_gnt) begin
        exp_cen = 0; exp_wen = !dma_we; exp_ben = dma_ben; exp_addr = dma_addr; exp_din = dma_wdata;
      end else if (owed) begin
        exp_cen = 1; exp_wen = 1; exp_ben = core_ben; exp_addr = core_addr; exp_din = core_din;
      end else begin
        exp_cen = core_cen; exp_wen = core_wen; exp_ben = core_ben; exp_addr = core_addr; exp_din = core_din;
      end

      @(negedge clk);
      n_checks++; if (dma_gnt !== exp_gnt) $display("FAIL rnd_gnt[%0d]: got %b want %b", c, dma_gnt, exp_gnt); else n_pass++;
      n_checks++; if (core_stall !== exp_stall) $display("FAIL rnd_stall[%0d]: got %b want %b", c, core_stall, exp_stall); else n_pass++;
      n_checks++; if (sram_cen !== exp_cen) $display("FAIL rnd_cen[%0d]: got %b want %b", c, sram_cen, exp_cen); else n_pass++;
      if (!exp_cen) begin
        n_checks++; if (sram_wen !== exp_wen) $display("FAIL rnd_wen[%0d]: got %b want %b", c, sram_wen, exp_wen); else n_pass++;
        n_checks++; if (sram_addr !== exp_addr) $display("FAIL rnd_addr[%0d]: got %h want %h", c, sram_addr, exp_addr); else n_pass++;
        n_checks++; if (sram_ben !== exp_ben) $display("FAIL rnd_ben[%0d]: got %h want %h", c, sram_ben, exp_ben); else n_pass++;
        if (!exp_wen) begin
          n_checks++; if (sram_din !== exp_din) $display("FAIL rnd_din[%0d]: got %h want %h", c, sram_din, exp_din); else n_pass++;
        end
      end
      n_checks++; if (dma_rvalid !== dma_pend) $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, dma_rvalid, dma_pend); else n_pass++;
      if (dma_pend) begin
        n_checks++; if (dma_rdata !== dma_exp) $display("FAIL rnd_rdata[%0d]: got %h want %h", c, dma_rdata, dma_exp); else n_pass++;
      end
      if (core_pend) begin
        n_checks++; if (core_dout !== core_exp) $display("FAIL rnd_core_dout[%0d]: got %h want %h", c, core_dout, core_exp); else n_pass++;
      end

      // Advance the model with this cycle's access and arbitration outcome.
      dma_pend  = 0;
      core_pend = 0;
      if (!exp_cen) begin
        idx = int'(exp_addr[9:2]);
        if (!exp_wen) begin
          ref_mem[idx] = merge(ref_mem[idx], exp_din, exp_ben);
        end else if (exp_gnt) begin
          dma_pend = 1; dma_exp = ref_mem[idx];
        end else begin
          core_pend = 1; core_exp = ref_mem[idx];
        end
      end
      if (exp_gnt) txn_active = 0;
      core_hold = exp_stall;
      if (owed) begin
        owed = 0; run = 0;
      end else if (dma_req && !core_cen) begin
        run++;
        if (run == MAX_WAIT) owed = 1;
      end else begin
        run = 0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_idle_write_read();
    test_starvation();
    test_count_clear();
    test_withdrawal();
    test_stall_no_req();
    test_reset_mid();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
